// File: rtl/onehot_decoder_seq.sv
// One-hot decoder with direct (handshaked select) and auto-scan modes.
// Define ONEHOT_ACTIVE_LOW_EN to invert d (selected bit low, blanked = all ones).
module onehot_decoder_seq #(
   parameter int N        = 3,
   parameter int SCAN_DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [(2**N)-1:0]  d,
   output logic [N-1:0]       idx,
   output logic               out_valid
);

   localparam int W = 2**N;

`ifdef ONEHOT_ACTIVE_LOW_EN
   localparam logic ACTIVE_LOW = 1'b1;
`else
   localparam logic ACTIVE_LOW = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [N-1:0]  idx_reg, idx_next;
   logic [15:0]   presc_reg, presc_next;
   logic          mode_reg, mode_next;
   logic          out_valid_reg, out_valid_next;
   logic [W-1:0]  d_reg, d_next;
   logic [W-1:0]  dec_next;
   logic          mode_change;
   logic          blank_next;

   assign mode_change = mode ^ mode_reg;
   assign in_ready    = ~rst & en & ~mode & ~mode_change;

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      presc_next     = presc_reg;
      mode_next      = mode_reg;
      out_valid_next = 1'b0;
      if (en) begin
         if (mode_change) begin
            // The switching edge only re-arms; the new mode takes effect next cycle.
            mode_next  = mode;
            idx_next   = '0;
            presc_next = '0;
            state_next = mode ? SCAN : IDLE;
         end else if (mode_reg) begin
            state_next = SCAN;
            if (presc_reg == 16'(SCAN_DIV - 1)) begin
               presc_next = '0;
               idx_next   = idx_reg + N'(1);
            end else begin
               presc_next = presc_reg + 16'd1;
            end
         end else if (in_valid) begin
            idx_next       = sel;
            state_next     = DIRECT;
            out_valid_next = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_dec
         assign dec_next[gi] = (idx_next == N'(gi));
      end
   endgenerate

   assign blank_next = ~en | (state_next == IDLE);
   assign d_next     = (blank_next ? '0 : dec_next) ^ {W{ACTIVE_LOW}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         presc_reg     <= '0;
         mode_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         d_reg         <= {W{ACTIVE_LOW}};
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         presc_reg     <= presc_next;
         mode_reg      <= mode_next;
         out_valid_reg <= out_valid_next;
         d_reg         <= d_next;
      end
   end

   assign d         = d_reg;
   assign idx       = idx_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_onehot_decoder_seq;

   localparam int N        = 3;
   localparam int SCAN_DIV = 4;
   localparam int W        = 2**N;

`ifdef ONEHOT_ACTIVE_LOW_EN
   localparam logic [W-1:0] POL = '1;
`else
   localparam logic [W-1:0] POL = '0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic [N-1:0]  sel = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  d;
   logic [N-1:0]  idx;
   logic          out_valid;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   // Behavioural model state
   int  m_mode = 0;
   int  m_idx = 0;
   int  m_cnt = 0;
   bit  m_shown = 0;
   bit  m_ov = 0;
   logic [W-1:0] m_d = POL;

   onehot_decoder_seq #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_ready(in_ready), .d(d), .idx(idx),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] oh(input int i);
      logic [W-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v ^ POL;
   endfunction

   always @(posedge clk) begin
      m_ov = 0;
      if (rst) begin
         m_mode = 0; m_idx = 0; m_cnt = 0; m_shown = 0;
      end else if (en) begin
         if (int'(mode) != m_mode) begin
            m_mode = mode; m_idx = 0; m_cnt = 0; m_shown = mode;
         end else if (m_mode == 1) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == SCAN_DIV) begin
               m_cnt = 0;
               m_idx = (m_idx + 1) % W;
            end
            m_shown = 1;
         end else if (in_valid) begin
            m_idx = sel; m_shown = 1; m_ov = 1;
         end
      end
      m_d = (!rst && en && m_shown) ? oh(m_idx) : POL;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("d", d, m_d);
         chk("idx", idx, m_idx);
         chk("out_valid", out_valid, m_ov);
         chk("in_ready", in_ready, !rst && en && !mode && (int'(mode) == m_mode));
         chk("onehot", ($countones(d ^ POL) <= 1), 1'b1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      step(); step();
      started = 1;
      step();
      chk("reset d", d, POL);
      chk("reset idx", idx, 0);
      chk("reset ov", out_valid, 0);
      rst = 0; en = 1; #1;
      chk("ready after reset", in_ready, 1);

      // Direct sweep of every select value
      for (int s = 0; s < W; s++) begin
         sel = N'(s); in_valid = 1; step();
         chk("sweep d", d, (64'h1 << s) ^ 64'(POL));
         chk("sweep ov", out_valid, 1);
      end
      in_valid = 0; step();
      chk("sweep hold d", d, 64'h80 ^ 64'(POL));
      chk("sweep hold ov", out_valid, 0);

      // Auto-scan for 40 cycles
      mode = 1; step();
      chk("scan start d", d, 64'h01 ^ 64'(POL));
      for (int k = 2; k <= 40; k++) step();
      chk("scan idx after 40", idx, 1);

      // Reset in the middle of a scan
      found = 0;
      for (int k = 0; k < 64 && !found; k++) begin
         if (idx == 3'd5) found = 1; else step();
      end
      chk("scan reached idx5", found, 1);
      rst = 1; mode = 0; step();
      chk("midscan rst idx", idx, 0);
      chk("midscan rst d", d, POL);
      rst = 0; #1;
      chk("ready after midscan rst", in_ready, 1);

      // Enable drop holds and blanks
      sel = 3'd4; in_valid = 1; step();
      chk("pre-en d", d, 64'h10 ^ 64'(POL));
      in_valid = 0; step();
      en = 0; sel = 3'd2; in_valid = 1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("en0 ready", in_ready, 0);
         step();
      end
      chk("en0 d", d, POL);
      chk("en0 idx", idx, 4);
      en = 1; in_valid = 0; step();
      chk("en restore d", d, 64'h10 ^ 64'(POL));
      in_valid = 1; sel = 3'd2; step();
      chk("post-en d", d, 64'h04 ^ 64'(POL));

      // Mode toggle coinciding with a valid select
      mode = 1; sel = 3'd6; in_valid = 1; step();
      chk("toggle ov", out_valid, 0);
      chk("toggle idx", idx, 0);
      chk("toggle d", d, 64'h01 ^ 64'(POL));

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 59) == 0);
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) mode = ~mode;
         in_valid = $urandom_range(0, 1);
         sel = N'($urandom);
         step();
      end
      rst = 0;
      started = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles per scan step; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  block enable; 0 freezes all state and blanks d.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 sel  input  N  select value, sampled on an accepted transfer.
REQ-008 in_valid  input  1  sel is valid this cycle.
REQ-009 in_ready  output  1  block accepts sel this cycle.
REQ-010 d  output  2**N  registered one-hot decode output.
REQ-011 idx  output  N  index currently driven on d.
REQ-012 out_valid  output  1  one-cycle pulse: d/idx were updated from an accepted sel.

Function
REQ-013 Output polarity: bit idx of d is 1 and all other bits are 0 when active; all bits 0 when blanked.
REQ-014 in_ready = en & ~mode & ~mode_change, combinational; a transfer is accepted when in_valid & in_ready.
REQ-015 Direct mode: an accepted sel loads idx <= sel and d <= one-hot(sel) on the same edge; latency is 1 cycle from acceptance to d.
REQ-016 Direct mode: out_valid is 1 for exactly the cycle after each acceptance; back-to-back acceptances give consecutive pulses; d/idx hold when no transfer occurs.
REQ-017 Scan mode: a prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and idx <= idx+1 modulo 2**N (2**N-1 wraps to 0); d tracks one-hot(idx).
REQ-018 SCAN_DIV = 1: idx advances every enabled cycle.
REQ-019 Scan mode: out_valid stays 0 and sel/in_valid are ignored.
REQ-020 Mode change (mode differs from its registered value): on that edge idx <= 0, prescaler <= 0, and no transfer is accepted; the new mode applies from the next cycle.
REQ-021 State machine: IDLE (d blanked, after reset or before first transfer in direct mode), DIRECT (holding decoded idx), SCAN (stepping); IDLE->DIRECT on acceptance, any->SCAN when mode=1 and en=1, SCAN->IDLE on mode change to 0.
REQ-022 en = 0: d is blanked, out_valid is 0, idx, prescaler and state hold; on en returning to 1, d resumes from the held idx and state.

Reset
REQ-023 On rst=1 at a clock edge: state IDLE, idx=0, prescaler=0, registered mode=0, out_valid=0, d blanked.
REQ-024 rst takes priority over en, mode and any transfer in the same cycle; in_ready is 0 while rst is 1.
REQ-025 Reset mid-scan or mid-transfer discards all in-flight state; no out_valid pulse follows reset.

Configuration
REQ-026 Macro ONEHOT_ACTIVE_LOW_EN defined: d is inverted (selected bit 0, others 1; blanked = all ones); timing, idx and handshakes unchanged.
REQ-027 Macro undefined: active-high polarity per REQ-013.

Verification
REQ-028 N=3, direct: sel=0..7 in consecutive accepted cycles -> d=01h,02h,04h,...,80h one cycle after each, out_valid pulses eight consecutive cycles.
REQ-029 N=3, SCAN_DIV=4, mode=1 for 40 cycles -> idx steps every 4 cycles 0..7 then wraps to 0; d never has more than one bit set; out_valid=0 throughout.
REQ-030 Scan running at idx=5, rst=1 one cycle -> next cycle idx=0, d=00h, out_valid=0; in_ready=1 once rst=0 with mode=0.
REQ-031 Direct mode, d=10h, en=0 for 3 cycles with in_valid=1, sel=2 -> d=00h, in_ready=0, no acceptance; en=1 -> d=10h restored, then sel=2 accepted -> d=04h.
REQ-032 mode toggles 0->1 in same cycle as in_valid=1, sel=6 -> transfer not accepted, idx=0, scan starts at d=01h.
REQ-033 Build with ONEHOT_ACTIVE_LOW_EN, sel=3 accepted -> d=F7h; after reset d=FFh.
